// File: rtl/spi_reg_ctrl.sv
// SPI slave (mode 0, oversampled in the clk domain) that frames addr+data bytes into a register bank.
// Optional MISO readback of reg[addr] during read frames is enabled with `define SPI_READBACK_EN.
module spi_reg_ctrl #(
  parameter int NREGS   = 4,
  parameter int SYNC_FF = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_sclk,
  input  logic                 spi_cs,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [8*NREGS-1:0]   regs_flat,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr,
  output logic [7:0]           frame_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic [SYNC_FF-1:0] sclk_sync, cs_sync, mosi_sync;
  logic [SYNC_FF:0]   fill;
  logic               sclk_d, cs_d, mosi_d, armed;
  logic               sclk_rise, cs_rise, cs_fall;
`ifdef SPI_READBACK_EN
  logic               sclk_fall;
  logic [7:0]         rd_shift, rd_byte;
`endif

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  shifted;
  logic        rw, overrun;
  logic [6:0]  addr;
  logic [7:0]  regs [NREGS];

  assign shifted = {shift[6:0], mosi_d};

  // Synchronizers plus a registered edge detector; armed blocks a CS that was already low out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      mosi_d    <= 1'b0;
      fill      <= '0;
      armed     <= 1'b0;
      sclk_rise <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
`ifdef SPI_READBACK_EN
      sclk_fall <= 1'b0;
`endif
    end else begin
      sclk_sync <= {sclk_sync[SYNC_FF-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_FF-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_FF-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_FF-1];
      cs_d      <= cs_sync[SYNC_FF-1];
      mosi_d    <= mosi_sync[SYNC_FF-1];
      fill      <= {fill[SYNC_FF-1:0], 1'b1};
      armed     <= armed | (fill[SYNC_FF] & cs_sync[SYNC_FF-1]);
      sclk_rise <= sclk_sync[SYNC_FF-1] & ~sclk_d;
      cs_rise   <= cs_sync[SYNC_FF-1] & ~cs_d;
      cs_fall   <= ~cs_sync[SYNC_FF-1] & cs_d & armed;
`ifdef SPI_READBACK_EN
      sclk_fall <= ~sclk_sync[SYNC_FF-1] & sclk_d;
`endif
    end
  end

`ifdef SPI_READBACK_EN
  // Register selected by the address byte as it completes; zero when out of range.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      if ({shift[5:0], mosi_d} == 7'(k)) rd_byte = regs[k];
    end
  end
`endif

  // Frame FSM, register bank commit and error counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 5'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
      addr      <= 7'd0;
      overrun   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= 7'd0;
      frame_err <= 8'h00;
      spi_miso  <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs[k] <= 8'h00;
`ifdef SPI_READBACK_EN
      rd_shift  <= 8'h00;
`endif
    end else begin
      wr_strobe <= 1'b0;
      if (cs_rise) begin
        state    <= IDLE;
        spi_miso <= 1'b0;
        if (state == DONE && !overrun) begin
          if (!rw && ({1'b0, addr} < 8'(NREGS))) begin
            for (int k = 0; k < NREGS; k++) begin
              if (addr == 7'(k)) regs[k] <= shift;
            end
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
          end
        end else if (state != IDLE) begin
          if (frame_err != 8'hFF) frame_err <= frame_err + 8'd1;
        end
      end else if (cs_fall) begin
        state    <= ADDR;
        bit_cnt  <= 5'd0;
        overrun  <= 1'b0;
        spi_miso <= 1'b0;
      end else if (sclk_rise && !cs_d) begin
        case (state)
          ADDR: begin
            shift   <= shifted;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              rw    <= shifted[7];
              addr  <= shifted[6:0];
              state <= DATA;
`ifdef SPI_READBACK_EN
              spi_miso <= shifted[7] & rd_byte[7];
              rd_shift <= shifted[7] ? {rd_byte[6:0], 1'b0} : 8'h00;
`endif
            end
          end
          DATA: begin
            shift   <= shifted;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state    <= DONE;
              spi_miso <= 1'b0;
            end
          end
          DONE:    overrun <= 1'b1;
          default: ;
        endcase
`ifdef SPI_READBACK_EN
      // The fall right after the address byte keeps bit 7 on the line for the first data rise.
      end else if (sclk_fall && state == DATA && rw && bit_cnt != 5'd8) begin
        spi_miso <= rd_shift[7];
        rd_shift <= {rd_shift[6:0], 1'b0};
`endif
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NREGS; k++) regs_flat[8*k +: 8] = regs[k];
  end

endmodule
